// File: rtl/handshake_mem_if.sv
// Request/response bus of the handshake memory.
// The master issues requests and consumes responses; the slave is the memory.
interface handshake_mem_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_wen;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [DATA_WIDTH-1:0]   resp_rdata;
    logic                    resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/handshake_mem.sv
// Single-port ideal memory behind a valid/ready request channel.
// Reads are sampled at the accepting edge, travel down a fixed-latency
// delay line and land in an in-order response FIFO whose head drives the
// response channel directly. A credit counter covering the delay line plus
// the FIFO keeps the FIFO from ever overflowing.
module handshake_mem #(
    parameter int    ADDR_WIDTH = 10,
    parameter int    DATA_WIDTH = 32,
    parameter int    RD_LATENCY = 2,
    parameter int    RESP_DEPTH = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic           clk,
    input  logic           rst,
    handshake_mem_if.slave bus
);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int OFF_W   = $clog2(STRB_W);
    localparam int WORD_AW = ADDR_WIDTH - OFF_W;
    localparam int N_WORDS = 1 << WORD_AW;
    localparam int CNT_W   = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFF_W) - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
        $error("handshake_mem: RD_LATENCY %0d outside 1..8", RD_LATENCY);
    end

    // Storage
    logic [DATA_WIDTH-1:0] mem_q [N_WORDS];

    // Request side
    logic               accept;
    logic               misaligned;
    logic [WORD_AW-1:0] word_idx;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

    assign misaligned    = |(bus.req_addr & ALIGN_MASK);
    assign word_idx      = bus.req_addr[ADDR_WIDTH-1:OFF_W];
    assign bus.req_ready = !rst && (out_cnt_q < CNT_W'(RESP_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;

    // Delay line: valid / force-zero / error bits are reset, data is not.
    logic [RD_LATENCY-1:0] pv_q;
    logic [RD_LATENCY-1:0] pz_q;
    logic [RD_LATENCY-1:0] pe_q;
    logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];

    // Strobed write, registered read and data shift; no reset so storage maps to block RAM.
    always_ff @(posedge clk) begin
        if (accept && bus.req_wen && !misaligned) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (bus.req_wstrb[i]) begin
                    mem_q[word_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
        // Old contents are captured on a same-edge write; write responses carry zero anyway.
        pd_q[0] <= mem_q[word_idx];
        for (int i = 1; i < RD_LATENCY; i++) begin
            pd_q[i] <= pd_q[i-1];
        end
    end

    // Control bits of the delay line; reset drops every in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
            pz_q <= '0;
            pe_q <= '0;
        end else begin
            pv_q[0] <= accept;
            pz_q[0] <= bus.req_wen || misaligned;
            pe_q[0] <= misaligned;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pz_q[i] <= pz_q[i-1];
                pe_q[i] <= pe_q[i-1];
            end
        end
    end

    // Response FIFO
    logic [DATA_WIDTH-1:0] fifo_data_q [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] fifo_err_q;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    assign push      = pv_q[RD_LATENCY-1];
    assign push_data = pz_q[RD_LATENCY-1] ? '0 : pd_q[RD_LATENCY-1];
    assign pop       = resp_valid && bus.resp_ready;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state for FIFO pointers, FIFO occupancy and outstanding credits.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        out_cnt_d  = out_cnt_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
        if (accept && !pop) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!accept && pop) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    // FIFO payload storage; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_err_q[wr_ptr_q]  <= pe_q[RD_LATENCY-1];
        end
    end

    // Fall-through head; outputs read zero when the FIFO is empty.
    assign resp_valid     = (fifo_cnt_q != '0);
    assign resp_rdata     = resp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign resp_err       = resp_valid && fifo_err_q[rd_ptr_q];
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata;
    assign bus.resp_err   = resp_err;

    // A stalled response must not vanish or change.
    assert property (@(posedge clk) disable iff (rst)
        (resp_valid && !bus.resp_ready) |=>
        (resp_valid && $stable(resp_rdata) && $stable(resp_err)))
    else $error("handshake_mem: response changed while stalled");
endmodule

// File: tb/tb_handshake_mem.sv
// Bench for handshake_mem: a main instance (latency 2, depth 4) checked every
// cycle against a queue-based model, plus two depth-1 instances (latency 1
// and 8) for round-trip and throughput measurements.
module tb_handshake_mem;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int DEP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    handshake_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    handshake_mem #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT),
        .RESP_DEPTH(DEP), .INIT_FILE("")
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a word array and an ordered list of pending responses, each
    // tagged with the edge count at which it may first be presented.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          arrive;
    } resp_t;

    resp_t       mq[$];
    logic [31:0] mmem [256];
    int          edge_n = 0;
    bit          chk_en = 1'b0;

    function automatic bit model_valid();
        if (mq.size() == 0) return 1'b0;
        return edge_n >= mq[0].arrive;
    endfunction

    function automatic void model_accept(input logic w, input logic [9:0] a,
                                         input logic [31:0] d, input logic [3:0] s);
        resp_t e;
        int    wi;
        wi       = int'(a[9:2]);
        e.arrive = edge_n + LAT;
        e.err    = (a[1:0] != 2'b00);
        e.data   = 32'h0;
        if (!e.err) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) mmem[wi][8*i +: 8] = d[8*i +: 8];
            end else begin
                e.data = mmem[wi];
            end
        end
        mq.push_back(e);
    endfunction

    // Every-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit          ev;
            logic [31:0] ed;
            logic        ee;
            ev = model_valid();
            ed = ev ? mq[0].data : 32'h0;
            ee = ev ? mq[0].err : 1'b0;
            chk("req_ready", bus.req_ready, (!rst && mq.size() < DEP));
            chk("resp_valid", bus.resp_valid, ev);
            chk("resp_rdata", bus.resp_rdata, ed);
            chk("resp_err", bus.resp_err, ee);
        end
    end

    logic        act_acc, act_pop, act_ready_s;
    bit          last_macc;
    int          acc_edge = 0;

    // One clock cycle of stimulus with the model advanced at the edge.
    task automatic cycle(input logic r, input logic v, input logic w, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic rr);
        bit ev, acc, pop;
        rst            = r;
        bus.req_valid  = v;
        bus.req_wen    = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.req_wstrb  = s;
        bus.resp_ready = rr;
        @(negedge clk);
        act_ready_s = bus.req_ready;
        act_acc     = v && bus.req_ready;
        act_pop     = bus.resp_valid && rr;
        ev  = model_valid();
        acc = v && !r && (mq.size() < DEP);
        pop = ev && rr;
        last_macc = acc;
        @(posedge clk);
        edge_n++;
        if (r) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                model_accept(w, a, d, s);
                acc_edge = edge_n;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic rr);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, rr);
    endtask

    task automatic issue(input logic w, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic rr);
        int n = 0;
        do begin
            cycle(1'b0, 1'b1, w, a, d, s, rr);
            n++;
        end while (!last_macc && n < 64);
        if (!last_macc) chk("issue_accept", 1'b0, 1'b1);
    endtask

    task automatic wait_resp(output int lat, output logic [31:0] d, output logic e);
        int n = 0;
        while (!bus.resp_valid && n < 32) begin
            idle(1, 1'b1);
            n++;
        end
        chk("resp_arrives", bus.resp_valid, 1'b1);
        lat = edge_n - acc_edge;
        d   = bus.resp_rdata;
        e   = bus.resp_err;
        idle(1, 1'b1);
    endtask

    // Depth-1 instances for the latency sweep.
    bit [1:0] sweep_done = 2'b00;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_sweep
        localparam int SL = (gi == 0) ? 1 : 8;
        logic srst;
        handshake_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sbus ();
        handshake_mem #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(SL),
            .RESP_DEPTH(1), .INIT_FILE("")
        ) sdut (
            .clk(clk),
            .rst(srst),
            .bus(sbus)
        );

        initial begin
            int n, first, second, nacc;
            srst            = 1'b1;
            sbus.req_valid  = 1'b0;
            sbus.req_wen    = 1'b0;
            sbus.req_addr   = 10'h40;
            sbus.req_wdata  = 32'h0;
            sbus.req_wstrb  = 4'h0;
            sbus.resp_ready = 1'b1;
            repeat (2) @(posedge clk);
            #1 srst = 1'b0;
            // write round trip
            sbus.req_valid = 1'b1;
            sbus.req_wen   = 1'b1;
            sbus.req_wdata = 32'hC0DE_0000 + SL;
            sbus.req_wstrb = 4'hF;
            @(negedge clk);
            chk($sformatf("lat%0d_ready", SL), sbus.req_ready, 1'b1);
            @(posedge clk); #1;
            sbus.req_valid = 1'b0;
            n = 0;
            while (!sbus.resp_valid && n < 20) begin @(posedge clk); #1; n++; end
            chk($sformatf("lat%0d_wr_rtt", SL), n, SL);
            @(posedge clk); #1;
            // read round trip
            sbus.req_valid = 1'b1;
            sbus.req_wen   = 1'b0;
            @(posedge clk); #1;
            sbus.req_valid = 1'b0;
            n = 0;
            while (!sbus.resp_valid && n < 20) begin @(posedge clk); #1; n++; end
            chk($sformatf("lat%0d_rd_rtt", SL), n, SL);
            chk($sformatf("lat%0d_rd_data", SL), sbus.resp_rdata, 32'hC0DE_0000 + SL);
            @(posedge clk); #1;
            // back-to-back: accept, SL cycles to present, one to pop, one for the credit
            sbus.req_valid = 1'b1;
            first = -1; second = -1; nacc = 0;
            for (int c = 0; c < 3 * (SL + 2); c++) begin
                @(negedge clk);
                if (sbus.req_ready) begin
                    nacc++;
                    if (first < 0) first = c;
                    else if (second < 0) second = c;
                end
                @(posedge clk); #1;
            end
            sbus.req_valid = 1'b0;
            chk($sformatf("lat%0d_thr_accepts", SL), nacc, 3);
            chk($sformatf("lat%0d_thr_interval", SL), second - first, SL + 2);
            sweep_done[gi] = 1'b1;
        end
    end

    // Main sequence
    initial begin
        int          lat, npop, nacc, t;
        logic [31:0] d;
        logic        e;

        cycle(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        chk_en = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.req_ready, 1'b1);
        chk("post_rst_valid", bus.resp_valid, 1'b0);

        for (int w = 0; w < 16; w++) issue(1'b1, 10'(w * 4), $urandom, 4'hF, 1'b1);
        idle(6, 1'b1);

        // write then read
        issue(1'b1, 10'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        wait_resp(lat, d, e);
        chk("wr_latency", lat, 2);
        chk("wr_rdata", d, 32'h0);
        chk("wr_err", e, 1'b0);
        issue(1'b0, 10'h10, 32'h0, 4'h0, 1'b1);
        wait_resp(lat, d, e);
        chk("rd_latency", lat, 2);
        chk("rd_rdata", d, 32'hDEADBEEF);

        // byte strobes
        issue(1'b1, 10'h20, 32'h11223344, 4'hF, 1'b1);
        wait_resp(lat, d, e);
        issue(1'b1, 10'h20, 32'hAABBCCDD, 4'h5, 1'b1);
        wait_resp(lat, d, e);
        issue(1'b0, 10'h20, 32'h0, 4'h0, 1'b1);
        wait_resp(lat, d, e);
        chk("strobe_merge", d, 32'h11BB33DD);

        // backpressure up to full
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 10'(i * 4), 32'h0, 4'h0, 1'b0);
            nacc += int'(act_acc);
        end
        chk("bp_accepted", nacc, 4);
        chk("bp_ready_full", bus.req_ready, 1'b0);
        idle(1, 1'b1);
        npop = int'(act_pop);
        chk("bp_ready_back", bus.req_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            idle(1, 1'b1);
            npop += int'(act_pop);
        end
        chk("bp_pops", npop, 4);

        // misaligned accesses
        issue(1'b0, 10'h13, 32'h0, 4'h0, 1'b1);
        wait_resp(lat, d, e);
        chk("mis_rd_err", e, 1'b1);
        chk("mis_rd_data", d, 32'h0);
        issue(1'b1, 10'h22, 32'hFFFFFFFF, 4'hF, 1'b1);
        wait_resp(lat, d, e);
        chk("mis_wr_err", e, 1'b1);
        issue(1'b0, 10'h20, 32'h0, 4'h0, 1'b1);
        wait_resp(lat, d, e);
        chk("mis_wr_noupdate", d, 32'h11BB33DD);
        chk("mis_wr_noupdate_err", e, 1'b0);

        // reset with three reads in flight, and a request offered during reset
        for (int i = 0; i < 3; i++) issue(1'b0, 10'h10, 32'h0, 4'h0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 10'h10, 32'h0, 4'h0, 1'b0);
        chk("rst_ready_during", act_ready_s, 1'b0);
        chk("rst_no_accept", act_acc, 1'b0);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        npop = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1, 1'b1);
            npop += int'(act_pop);
        end
        chk("rst_no_stale", npop, 0);
        issue(1'b0, 10'h10, 32'h0, 4'h0, 1'b1);
        wait_resp(lat, d, e);
        chk("rst_after_latency", lat, 2);
        chk("rst_after_data", d, 32'hDEADBEEF);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            logic [9:0] a;
            a = 10'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 10'($urandom_range(1, 3));
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 60,
                  1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 70);
        end
        idle(16, 1'b1);
        chk("drained", bus.resp_valid, 1'b0);

        t = 0;
        while (sweep_done != 2'b11 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (sweep_done != 2'b11) chk("sweep_done", sweep_done, 2'b11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
